// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer clock-source switch sequencer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OLD = 2'd1,
        GAP      = 2'd2,
        WAIT_NEW = 2'd3
    } sw_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/timer_sync_edge.sv
// Multi-flop synchroniser for one asynchronous timer source plus a rising-edge detector.
module timer_sync_edge
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q    = r_sync[SYNC_STAGES-1];
    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/timer_src_switch_ctrl.sv
// Glitch-free timer source select: the mux only moves while both sources are low,
// with a guard gap, and ticks are counted from the selected source while idle.
module timer_src_switch_ctrl
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_a,
    input  logic             src_b,
    input  logic             req_valid,
    input  logic             req_sel,
    output logic             req_ready,
    output logic             mux_sel,
    output logic             busy,
    output logic             tick_out,
    output logic [CNT_W-1:0] tick_cnt,
    input  logic             cnt_clr,
    output logic             timeout_err
);

    localparam int                WCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TO_VAL   = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] GAP_LAST = WCNT_W'(GAP_CYC - 1);

    sw_state_e         r_state;
    logic              r_mux_sel;
    logic              r_tgt;
    logic              r_timeout_err;
    logic              r_tick_out;
    logic [WCNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0]  r_tick_cnt;

    logic              w_q_a, w_rise_a, w_q_b, w_rise_b;
    logic              w_q_old, w_q_new, w_rise_sel, w_tick, w_wait_to;
    logic [WCNT_W-1:0] w_wcnt_inc;

    timer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (src_a),
        .q    (w_q_a),
        .rise (w_rise_a)
    );

    timer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (src_b),
        .q    (w_q_b),
        .rise (w_rise_b)
    );

    assign w_q_old    = (r_mux_sel == SEL_B) ? w_q_b : w_q_a;
    assign w_q_new    = (r_tgt == SEL_B) ? w_q_b : w_q_a;
    assign w_rise_sel = (r_mux_sel == SEL_B) ? w_rise_b : w_rise_a;
    // Edges seen mid-switch are dropped rather than queued for later.
    assign w_tick     = (r_state == IDLE) & w_rise_sel;
    assign w_wait_to  = (r_wcnt == TO_VAL);
    assign w_wcnt_inc = w_wait_to ? r_wcnt : r_wcnt + WCNT_W'(1);

    // A source found low in the same cycle the timeout expires takes the clean path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_mux_sel     <= SEL_A;
            r_tgt         <= SEL_A;
            r_wcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && (req_sel != r_mux_sel)) begin
                        r_tgt         <= req_sel;
                        r_timeout_err <= 1'b0;
                        r_wcnt        <= '0;
                        r_state       <= WAIT_OLD;
                    end
                end
                WAIT_OLD: begin
                    if (!w_q_old) begin
                        r_wcnt  <= '0;
                        r_state <= GAP;
                    end else if (w_wait_to) begin
                        r_mux_sel     <= r_tgt;
                        r_timeout_err <= 1'b1;
                        r_wcnt        <= '0;
                        r_state       <= IDLE;
                    end else begin
                        r_wcnt <= w_wcnt_inc;
                    end
                end
                GAP: begin
                    if (r_wcnt == GAP_LAST) begin
                        r_wcnt  <= '0;
                        r_state <= WAIT_NEW;
                    end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                WAIT_NEW: begin
                    if (!w_q_new) begin
                        r_mux_sel <= r_tgt;
                        r_wcnt    <= '0;
                        r_state   <= IDLE;
                    end else if (w_wait_to) begin
                        r_mux_sel     <= r_tgt;
                        r_timeout_err <= 1'b1;
                        r_wcnt        <= '0;
                        r_state       <= IDLE;
                    end else begin
                        r_wcnt <= w_wcnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_out <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_tick_out <= w_tick;
            if (cnt_clr) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign mux_sel     = r_mux_sel;
    assign tick_out    = r_tick_out;
    assign tick_cnt    = r_tick_cnt;
    assign timeout_err = r_timeout_err;

endmodule
